// File: rtl/cc_pkg.sv
// Shared types for the condition-code / branch controller.
// Holds the FSM encoding, the N/Z/P bit positions and the decode helper.
package cc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BR_EVAL = 2'd1,
    BR_TAKE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned N_IDX = 2;
  localparam int unsigned Z_IDX = 1;
  localparam int unsigned P_IDX = 0;

  localparam logic [2:0] NZP_RST = 3'b010;

  function automatic logic [2:0] nzp_of(input logic [15:0] d);
    logic [2:0] c;
    c = '0;
    if (d == 16'h0000) begin
      c[Z_IDX] = 1'b1;
    end else if (d[15]) begin
      c[N_IDX] = 1'b1;
    end else begin
      c[P_IDX] = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/cc_reg.sv
// N/Z/P condition-code register.
// Loads a one-hot code derived from the bus when load is high.
module cc_reg
  import cc_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Data,
  input  logic        load,
  output logic        n,
  output logic        z,
  output logic        p
);

  logic [2:0] cc_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cc_q <= NZP_RST;
    end else if (load) begin
      cc_q <= nzp_of(Data);
    end
  end

  assign n = cc_q[N_IDX];
  assign z = cc_q[Z_IDX];
  assign p = cc_q[P_IDX];

endmodule

// File: rtl/cc_branch_ctrl.sv
// Condition-code load and conditional-branch controller.
// Loads N/Z/P, evaluates branch masks and handshakes the PC load.
module cc_branch_ctrl
  import cc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Data,
  input  logic        cc_req,
  input  logic        br_req,
  input  logic [2:0]  IR_nzp,
  input  logic        pc_ack,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic        cc_valid,
  output logic        ben,
  output logic        ld_pc,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     mask_q;
  logic           valid_q;
  logic           ben_q;
  logic           err_q;
  logic           cc_load;
  logic           ben_d;
  logic           timeout;

  assign cc_load = (state_q == IDLE) & cc_req;
  assign ben_d   = valid_q & (|(mask_q & {n, z, p}));

  // Timeout fires on the edge that would take the counter to TIMEOUT.
  assign timeout = (state_q == BR_TAKE) & ~pc_ack
                 & (cnt_q == CW'(TIMEOUT - 1));

  cc_reg u_cc_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .Data  (Data),
    .load  (cc_load),
    .n     (n),
    .z     (z),
    .p     (p)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (br_req) begin
          state_d = BR_EVAL;
        end else if (cc_req) begin
          state_d = DONE;
        end
      end
      BR_EVAL: state_d = ben_d ? BR_TAKE : DONE;
      BR_TAKE: begin
        if (pc_ack || timeout) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    ld_pc = (state_q == BR_TAKE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      ben_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == BR_EVAL) begin
        cnt_q <= '0;
      end else if (state_q == BR_TAKE) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if ((state_q == IDLE) && br_req) begin
        mask_q <= IR_nzp;
      end
      if (cc_load) begin
        valid_q <= 1'b1;
      end
      if (state_q == BR_EVAL) begin
        ben_q <= ben_d;
      end
      err_q <= timeout;
    end
  end

  assign cc_valid = valid_q;
  assign ben      = ben_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cc_branch_ctrl.sv
// Scoreboard bench for cc_branch_ctrl.
// Driver predicts each transaction; monitor checks on every done.
module tb_cc_branch_ctrl;

  localparam int TO = 15;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Data = '0;
  logic        cc_req = 1'b0;
  logic        br_req = 1'b0;
  logic [2:0]  IR_nzp = '0;
  logic        pc_ack = 1'b0;
  logic        n, z, p, cc_valid, ben, ld_pc, busy, done, err;

  cc_branch_ctrl #(.TIMEOUT(TO)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Data     (Data),
    .cc_req   (cc_req),
    .br_req   (br_req),
    .IR_nzp   (IR_nzp),
    .pc_ack   (pc_ack),
    .n        (n),
    .z        (z),
    .p        (p),
    .cc_valid (cc_valid),
    .ben      (ben),
    .ld_pc    (ld_pc),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int       lat;
    int       ld;
    bit       err;
    bit [2:0] nzp;
    bit       ben;
    bit       valid;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total = 0;
  int   ack_at = 0;

  bit [2:0] m_nzp = 3'b010;
  bit       m_valid = 1'b0;
  bit       m_ben = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit [2:0] cc_of(input logic [15:0] d);
    if (d == 16'h0000) return 3'b010;
    if ($signed(d) < 0) return 3'b100;
    return 3'b001;
  endfunction

  task automatic model_reset();
    m_nzp = 3'b010;
    m_valid = 1'b0;
    m_ben = 1'b0;
    q.delete();
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (done === 1'b1) break;
    end
    if (i == 60) chk(nm, {31'd0, done}, 32'd1);
  endtask

  task automatic do_txn(input bit c, input bit b, input logic [15:0] d,
                        input logic [2:0] m, input int a);
    exp_t e;
    bit   taken;
    if (!c && !b) begin
      cc_req = 1'b0;
      br_req = 1'b0;
      @(negedge Clk);
      return;
    end
    if (c) begin
      m_nzp = cc_of(d);
      m_valid = 1'b1;
    end
    e.lat = 1;
    e.ld = 0;
    e.err = 1'b0;
    if (b) begin
      taken = m_valid && ((m & m_nzp) != 3'b000);
      m_ben = taken;
      e.lat = 2;
      if (taken) begin
        if (a >= 1 && a <= TO) begin
          e.ld = a;
        end else begin
          e.ld = TO;
          e.err = 1'b1;
        end
        e.lat = 2 + e.ld;
      end
    end
    e.nzp = m_nzp;
    e.ben = m_ben;
    e.valid = m_valid;
    q.push_back(e);
    ack_at = a;
    Data = d;
    IR_nzp = m;
    cc_req = c;
    br_req = b;
    wait_done("txn_done_timeout");
    cc_req = 1'b0;
    br_req = 1'b0;
  endtask

  // pc_ack: random outside BR_TAKE, exactly on cycle ack_at inside it
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge Clk);
      if (ld_pc === 1'b1) begin
        cnt++;
        pc_ack = (cnt == ack_at);
      end else begin
        cnt = 0;
        pc_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int   cyc;
    int   ld;
    exp_t e;
    cyc = 0;
    ld = 0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        cyc = 0;
        ld = 0;
      end else if (busy === 1'b1) begin
        cyc++;
        ld += int'(ld_pc);
        if (done === 1'b1) begin
          if (q.size() == 0) begin
            chk("spurious_done", {31'd0, done}, 32'd0);
          end else begin
            e = q.pop_front();
            chk("latency", cyc, e.lat);
            chk("ld_pc_cycles", ld, e.ld);
            chk("err", {31'd0, err}, {31'd0, e.err});
            chk("nzp", {29'd0, n, z, p}, {29'd0, e.nzp});
            chk("ben", {31'd0, ben}, {31'd0, e.ben});
            chk("cc_valid", {31'd0, cc_valid}, {31'd0, e.valid});
          end
          cyc = 0;
          ld = 0;
        end
      end else if ((done | ld_pc | err) !== 1'b0) begin
        chk("idle_outputs", {29'd0, done, ld_pc, err}, 32'd0);
      end
    end
  end

  initial begin
    repeat (2) @(negedge Clk);
    #1;
    chk("reset_state",
        {23'd0, n, z, p, cc_valid, ben, ld_pc, busy, done, err},
        32'b010000000);
    #1 Reset = 1'b1;
    @(negedge Clk);

    do_txn(1'b0, 1'b1, 16'h1234, 3'b111, 1);
    do_txn(1'b1, 1'b0, 16'h8001, 3'b000, 0);
    do_txn(1'b1, 1'b1, 16'h0000, 3'b010, 2);
    do_txn(1'b1, 1'b0, 16'h0005, 3'b000, 0);
    do_txn(1'b0, 1'b1, 16'h0000, 3'b100, 1);
    do_txn(1'b0, 1'b1, 16'h0000, 3'b001, 0);
    do_txn(1'b0, 1'b1, 16'h0000, 3'b001, TO);
    do_txn(1'b0, 1'b1, 16'h0000, 3'b011, TO + 1);

    for (int k = 0; k < 80; k++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
             3'($urandom), $urandom_range(0, 18));
    end

    // Reset in the middle of a taken branch
    Data = 16'h0000;
    IR_nzp = 3'b111;
    ack_at = 0;
    br_req = 1'b1;
    begin
      int i;
      for (i = 0; i < 10; i++) begin
        @(negedge Clk);
        if (ld_pc === 1'b1) break;
      end
    end
    chk("reach_br_take", {31'd0, ld_pc}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("reset_mid_take",
        {23'd0, n, z, p, cc_valid, ben, ld_pc, busy, done, err},
        32'b010000000);
    model_reset();
    br_req = 1'b0;
    begin
      exp_t e;
      m_nzp = cc_of(16'hFFFF);
      m_valid = 1'b1;
      e.lat = 1;
      e.ld = 0;
      e.err = 1'b0;
      e.nzp = m_nzp;
      e.ben = m_ben;
      e.valid = m_valid;
      q.push_back(e);
    end
    Data = 16'hFFFF;
    cc_req = 1'b1;
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    chk("accept_after_reset", {30'd0, busy, done}, 32'b11);
    cc_req = 1'b0;
    repeat (3) @(negedge Clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cc_branch_ctrl.md
CC_BRANCH_CTRL -- requirements
Module: cc_branch_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles spent in BR_TAKE waiting for pc_ack.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port Data, input, 16, the bus value sampled for condition codes.
REQ-005 The block SHALL have port cc_req, input, 1, a request to load N/Z/P from Data.
REQ-006 The block SHALL have port br_req, input, 1, a request to evaluate a conditional branch.
REQ-007 The block SHALL have port IR_nzp, input, 3, the branch mask {n,z,p} (IR[11:9]).
REQ-008 The block SHALL have port pc_ack, input, 1, the PC-load acknowledge from the datapath.
REQ-009 The block SHALL have ports n, z, p, output, 1 each, the registered condition codes.
REQ-010 The block SHALL have ports cc_valid (codes loaded since reset), ben (branch enable), ld_pc (PC load strobe), busy, done and err, output, 1 each.

Function
REQ-011 The FSM SHALL have states IDLE, BR_EVAL, BR_TAKE and DONE; busy SHALL be 1 in every state except IDLE.
REQ-012 Requests SHALL be sampled only in IDLE and ignored otherwise; requesters hold them until done.
REQ-013 In IDLE with cc_req=1, the block SHALL load at that edge: z=1 if Data==16'h0000; else n=Data[15], p=~Data[15]; exactly one of n/z/p set; cc_valid SHALL become 1.
REQ-014 In IDLE, the next state SHALL be: br_req=1 to BR_EVAL (IR_nzp latched that edge); cc_req=1 alone to DONE; neither to IDLE.
REQ-015 When cc_req and br_req are both 1, the CC load SHALL occur first and BR_EVAL SHALL use the newly loaded codes; done SHALL pulse once.
REQ-016 In BR_EVAL (one cycle), ben SHALL be registered as cc_valid & |(IR_nzp_latched & {n,z,p}); next state SHALL be BR_TAKE if ben, else DONE.
REQ-017 ben SHALL hold its value until the next BR_EVAL or reset.
REQ-018 In BR_TAKE, ld_pc SHALL be 1 (Moore output) and a wait counter SHALL increment each cycle.
REQ-019 In BR_TAKE, pc_ack=1 SHALL cause DONE next cycle.
REQ-020 In BR_TAKE, reaching the counter value TIMEOUT without pc_ack SHALL force DONE with err asserted for that DONE cycle.
REQ-021 If pc_ack coincides with the timeout, pc_ack SHALL win and err SHALL stay 0.
REQ-022 pc_ack SHALL be ignored outside BR_TAKE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 Back-to-back requests SHALL be accepted in the IDLE cycle following DONE.
REQ-025 Latency from acceptance to done SHALL be: CC only 1 cycle; branch not taken 2 cycles; branch taken 3+k cycles, where k is the number of pc_ack wait cycles.
REQ-026 The wait counter SHALL be ceil(log2(TIMEOUT+1)) bits wide and clear on entry to BR_TAKE.

Reset
REQ-027 Reset low SHALL immediately force state=IDLE, n=0, z=1, p=0, cc_valid=0, ben=0, counter=0, and ld_pc=busy=done=err=0.
REQ-028 Reset asserted mid-operation (including in BR_TAKE) SHALL abandon the operation with no done pulse.
REQ-029 A branch evaluated with cc_valid=0 SHALL be not taken.

Structure
REQ-030 A shared package cc_pkg SHALL hold the state enum and the N/Z/P bit-index constants.
REQ-031 The N/Z/P register with its load enable SHALL be one sub-module, cc_reg (Clk, Reset, Data, load, n/z/p).

Verification
REQ-032 Reset then cc_req with Data=16'h8001 -> n=1 z=0 p=0 cc_valid=1, done high 1 cycle after acceptance.
REQ-033 cc_req and br_req together with Data=16'h0000, IR_nzp=3'b010, pc_ack on the 2nd BR_TAKE cycle -> z=1, ben=1, ld_pc high 2 cycles, single done pulse.
REQ-034 CC loaded with p=1, then br_req with IR_nzp=3'b100 -> ben=0, no ld_pc, done 2 cycles after acceptance.
REQ-035 br_req with IR_nzp=3'b111 immediately after reset -> ben=0 (cc_valid=0), not taken.
REQ-036 Taken branch with pc_ack held low -> ld_pc high for TIMEOUT=15 cycles, then done=1 and err=1 together.
REQ-037 Reset pulsed low during BR_TAKE -> outputs at reset values immediately, no done; cc_req accepted on the first edge after release.
